// File: rtl/store_buffer.sv
// store_buffer: post-LSU store queue.
//   Holds translated, exception-free stores speculatively until the ROB
//   retires them, then drains committed stores in order to the dbus. Also
//   flags pending loads that overlap any buffered store.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             discard uncommitted entries (committed ones survive)
//   push, push_req    enqueue a store request
//   full, empty       occupancy flags (from registered pointers only)
//   commit            ROB retired the oldest uncommitted store
//   dbus_req          head store presented to the dbus (zero when idle)
//   dbus_request      head entry is committed and being presented
//   dbus_ready        dbus accepted dbus_req this cycle
//   query_paddr/_byteenable  address and bytes of a pending load
//   query_conflict    load overlaps a buffered store
//   committed_cnt     committed, not yet drained entries
//
// Optional feature (macro STORE_BUFFER_FWD_EN):
//   adds fwd_hit / fwd_data. When the youngest overlapping store covers all
//   bytes of the load, its data is forwarded and query_conflict stays low.

package store_buffer_pkg;
  typedef struct packed {
    logic        read;
    logic        write;
    logic        invalidate;
    logic        invalidate_icache;
    logic        uncached;
    logic [31:0] paddr;
    logic [3:0]  byteenable;
    logic [31:0] wrdata;
  } data_memreq_t;
endpackage

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  data_memreq_t       push_req,
  output logic               full,
  output logic               empty,
  input  logic               commit,
  output data_memreq_t       dbus_req,
  output logic               dbus_request,
  input  logic               dbus_ready,
  input  logic [31:0]        query_paddr,
  input  logic [3:0]         query_byteenable,
  output logic               query_conflict,
  output logic [PTR_W:0]     committed_cnt
`ifdef STORE_BUFFER_FWD_EN
  ,
  output logic               fwd_hit,
  output logic [31:0]        fwd_data
`endif
);

  typedef logic [PTR_W:0]   ptr_t;
  typedef logic [PTR_W-1:0] idx_t;

  // Pointers carry a wrap bit so head == tail is unambiguous (empty vs full).
  ptr_t head_q, head_d;
  ptr_t cptr_q, cptr_d;
  ptr_t tail_q, tail_d;
  ptr_t count;

  data_memreq_t mem_q [DEPTH];

  logic push_ok;
  logic commit_ok;
  logic drain_ok;

  assign count         = tail_q - head_q;
  assign committed_cnt = cptr_q - head_q;
  assign full          = (count == ptr_t'(DEPTH));
  assign empty         = (count == '0);
  assign dbus_request  = (head_q != cptr_q);

  assign push_ok   = push & ~full & ~flush;
  // Compared against the registered tail, so a store pushed this cycle
  // cannot be committed in the same cycle.
  assign commit_ok = commit & (cptr_q != tail_q);
  assign drain_ok  = dbus_request & dbus_ready;

  always_comb begin
    head_d = drain_ok  ? head_q + ptr_t'(1) : head_q;
    cptr_d = commit_ok ? cptr_q + ptr_t'(1) : cptr_q;
    // Flush rolls tail back to the post-commit cptr; a same-cycle push is lost.
    if (flush) begin
      tail_d = cptr_d;
    end else if (push_ok) begin
      tail_d = tail_q + ptr_t'(1);
    end else begin
      tail_d = tail_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      cptr_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cptr_q <= cptr_d;
      tail_q <= tail_d;
    end
  end

  // Payload storage needs no reset: occupancy comes from the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[tail_q[PTR_W-1:0]] <= push_req;
    end
  end

  always_comb begin
    dbus_req = '0;
    if (dbus_request) begin
      dbus_req                   = mem_q[head_q[PTR_W-1:0]];
      dbus_req.read              = 1'b0;
      dbus_req.write             = 1'b1;
      dbus_req.invalidate        = 1'b0;
      dbus_req.invalidate_icache = 1'b0;
    end
  end

  // Walk entries oldest to youngest so the last match is the youngest one.
  logic        any_match;
  logic [3:0]  young_be;
  logic [31:0] young_data;
  idx_t        slot;

  always_comb begin
    any_match  = 1'b0;
    young_be   = '0;
    young_data = '0;
    slot       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_q[PTR_W-1:0] + idx_t'(k);
      if ((ptr_t'(k) < count) &&
          (mem_q[slot].paddr[31:2] == query_paddr[31:2]) &&
          (|(mem_q[slot].byteenable & query_byteenable))) begin
        any_match  = 1'b1;
        young_be   = mem_q[slot].byteenable;
        young_data = mem_q[slot].wrdata;
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic fwd_cover;
  assign fwd_cover      = ((young_be & query_byteenable) == query_byteenable);
  assign fwd_hit        = any_match & fwd_cover;
  assign fwd_data       = fwd_hit ? young_data : '0;
  assign query_conflict = any_match & ~fwd_cover;
`else
  logic [35:0] unused_young;
  assign unused_young   = {young_be, young_data};
  assign query_conflict = any_match;
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           push;
  data_memreq_t   push_req;
  logic           full;
  logic           empty;
  logic           commit;
  data_memreq_t   dbus_req;
  logic           dbus_request;
  logic           dbus_ready;
  logic [31:0]    query_paddr;
  logic [3:0]     query_byteenable;
  logic           query_conflict;
  logic [PTR_W:0] committed_cnt;
`ifdef STORE_BUFFER_FWD_EN
  logic           fwd_hit;
  logic [31:0]    fwd_data;
`endif

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .push             (push),
    .push_req         (push_req),
    .full             (full),
    .empty            (empty),
    .commit           (commit),
    .dbus_req         (dbus_req),
    .dbus_request     (dbus_request),
    .dbus_ready       (dbus_ready),
    .query_paddr      (query_paddr),
    .query_byteenable (query_byteenable),
    .query_conflict   (query_conflict),
    .committed_cnt    (committed_cnt)
`ifdef STORE_BUFFER_FWD_EN
    ,
    .fwd_hit          (fwd_hit),
    .fwd_data         (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted store in program order; the first mc are committed.
  data_memreq_t exp_q[$];
  int mc = 0;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic data_memreq_t mk(input logic [31:0] a, input logic [3:0] be,
                                      input logic [31:0] d);
    data_memreq_t r;
    r                   = '0;
    r.write             = 1'b1;
    r.read              = d[0];    // garbage control bits must be cleaned on drain
    r.invalidate        = d[1];
    r.invalidate_icache = d[2];
    r.uncached          = a[4];
    r.paddr             = a;
    r.byteenable        = be;
    r.wrdata            = d;
    return r;
  endfunction

  function automatic data_memreq_t norm(input data_memreq_t r);
    data_memreq_t n;
    n                   = r;
    n.read              = 1'b0;
    n.write             = 1'b1;
    n.invalidate        = 1'b0;
    n.invalidate_icache = 1'b0;
    return n;
  endfunction

  task automatic model_query(output logic conf, output logic hit, output logic [31:0] fd);
    logic        any;
    logic [3:0]  ybe;
    logic [31:0] yd;
    any = 1'b0; ybe = '0; yd = '0;
    foreach (exp_q[i]) begin
      if (exp_q[i].paddr[31:2] == query_paddr[31:2] &&
          (exp_q[i].byteenable & query_byteenable) != 4'b0) begin
        any = 1'b1;
        ybe = exp_q[i].byteenable;
        yd  = exp_q[i].wrdata;
      end
    end
`ifdef STORE_BUFFER_FWD_EN
    hit  = any && ((ybe & query_byteenable) == query_byteenable);
    conf = any && !hit;
    fd   = hit ? yd : 32'h0;
`else
    hit  = 1'b0;
    conf = any;
    fd   = 32'h0;
`endif
  endtask

  task automatic step();
    logic        e_conf, e_hit;
    logic [31:0] e_fd;
    int          sz;
    bit          do_drain, do_commit, do_push, do_flush;
    data_memreq_t pr;
    @(negedge clk);
    sz = exp_q.size();
    chk("full", full, sz == DEPTH);
    chk("empty", empty, sz == 0);
    chk("committed_cnt", committed_cnt, mc);
    chk("dbus_request", dbus_request, mc > 0);
    if (mc > 0) chk("dbus_req", dbus_req, exp_q[0]);
    else        chk("dbus_req_idle", dbus_req, '0);
    model_query(e_conf, e_hit, e_fd);
    chk("query_conflict", query_conflict, e_conf);
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd_hit", fwd_hit, e_hit);
    chk("fwd_data", fwd_data, e_fd);
`endif
    do_drain  = (mc > 0) && dbus_ready;
    do_commit = commit && (mc < sz);
    do_flush  = flush;
    do_push   = push && (sz < DEPTH) && !flush;
    pr        = push_req;
    @(posedge clk);
    if (do_drain) begin
      void'(exp_q.pop_front());
      mc--;
    end
    if (do_commit) mc++;
    if (do_flush) begin
      while (exp_q.size() > mc) void'(exp_q.pop_back());
    end else if (do_push) begin
      exp_q.push_back(norm(pr));
    end
    #1;
  endtask

  task automatic idle();
    flush = 0; push = 0; commit = 0; dbus_ready = 0;
    push_req = '0; query_paddr = '0; query_byteenable = '0;
  endtask

  task automatic do_push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    push = 1; push_req = mk(a, be, d);
    step();
    push = 0;
  endtask

  task automatic query(input logic [31:0] a, input logic [3:0] be);
    query_paddr = a; query_byteenable = be;
    step();
  endtask

  task automatic drain_all();
    int n;
    commit = 1; dbus_ready = 1; push = 0; flush = 0;
    n = 0;
    while (exp_q.size() > 0 && n < 64) begin
      step();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    commit = 0; dbus_ready = 0;
    step();
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_dbus_request", dbus_request, 1'b0);
    chk("rst_dbus_req", dbus_req, '0);
    chk("rst_conflict", query_conflict, 1'b0);
    chk("rst_ccnt", committed_cnt, 0);
    @(posedge clk); #1;
    rst = 0;
    step();

    // Three uncommitted stores: nothing is presented.
    do_push(32'h100, 4'hF, 32'hA0000001);
    do_push(32'h104, 4'hF, 32'hA0000002);
    do_push(32'h108, 4'hF, 32'hA0000004);
    step();
    step();

    // Two commits with the bus ready, then a stalled bus holding the head.
    dbus_ready = 1; commit = 1;
    step(); step();
    commit = 0;
    step(); step();
    dbus_ready = 0; commit = 1;
    step();
    commit = 0;
    repeat (3) step();
    dbus_ready = 1;
    step(); step();
    dbus_ready = 0;

    // Fill to full (pointers wrap), ninth push dropped, commit then drain+push.
    for (int i = 0; i < DEPTH; i++) do_push(32'h1000 + 32'(i * 4), 4'hF, 32'hB000_0000 + 32'(i));
    do_push(32'h2000, 4'hF, 32'hDEAD0000);
    commit = 1; step(); commit = 0;
    dbus_ready = 1; push = 1; push_req = mk(32'h2004, 4'hF, 32'hC0000010);
    step();
    dbus_ready = 0;
    step();      // same push now accepted into the freed slot
    push = 0;
    drain_all();

    // Push 4, commit 2, flush with simultaneous commit and push.
    for (int i = 0; i < 4; i++) do_push(32'h3000 + 32'(i * 4), 4'h3, 32'hE000_0000 + 32'(i));
    commit = 1; step(); step();
    flush = 1; push = 1; push_req = mk(32'h3100, 4'hF, 32'hF00DF00D);
    step();
    flush = 0; push = 0; commit = 0;
    step();
    dbus_ready = 1;
    repeat (4) step();
    dbus_ready = 0;

    // Byte-overlap queries.
    do_push(32'h200, 4'b0011, 32'h12345678);
    query(32'h200, 4'b0100);
    query(32'h200, 4'b0001);
    query(32'h204, 4'b1111);
    query(32'h202, 4'b0010);
    query_paddr = '0; query_byteenable = '0;
    drain_all();

    // Two stores to the same word: youngest forwards when feature enabled.
    do_push(32'h300, 4'b1111, 32'hAABBCCDD);
    do_push(32'h300, 4'b1111, 32'h11223344);
    query(32'h300, 4'b1111);
    query(32'h300, 4'b0110);
    do_push(32'h300, 4'b0001, 32'h55667788);
    query(32'h300, 4'b1111);   // youngest only partially covers
    query(32'h300, 4'b0001);
    query_paddr = '0; query_byteenable = '0;
    flush = 1; step(); flush = 0;   // all uncommitted: buffer empties
    step();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      push       = ($urandom_range(0, 99) < 55);
      push_req   = mk(32'h400 + 32'($urandom_range(0, 3) * 4),
                      4'($urandom_range(1, 15)), $urandom);
      commit     = ($urandom_range(0, 99) < 40);
      dbus_ready = ($urandom_range(0, 99) < 50);
      flush      = ($urandom_range(0, 99) < 4);
      query_paddr      = 32'h400 + 32'($urandom_range(0, 4) * 4);
      query_byteenable = 4'($urandom_range(0, 15));
      step();
    end
    idle();
    drain_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
